// File: rtl/rowbias_server.sv
// Row-bias responder: serves one-hot bias values from a per-row permutation
// table and reshuffles it in place with an LFSR-driven Fisher-Yates pass.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module rowbias_server #(
  parameter int          GRID_LEN  = `GRID_LEN,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                updaterowbias,
  input  logic [GRID_LEN:0]   rqindex,
  output logic [GRID_LEN-1:0] rowbias,
  output logic                rbvalid,
  output logic                ready,
  output logic                err
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam int          KW   = (GRID_LEN > 1) ? $clog2(GRID_LEN) : 1;
  localparam logic [GRID_LEN-1:0] ONE = GRID_LEN'(1);

  typedef enum logic {IDLE, SHUF} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [KW-1:0]       k_q, k_d;
  logic [GRID_LEN-1:0] tbl_q [GRID_LEN];
  logic [GRID_LEN-1:0] tbl_d [GRID_LEN];
  logic [GRID_LEN-1:0] rowbias_q, rowbias_d;
  logic                rbvalid_q, rbvalid_d;
  logic                err_q, err_d;
  logic [KW-1:0]       sel;
  logic [KW-1:0]       j;
  logic [7:0]          jm;

  assign rowbias = rowbias_q;
  assign rbvalid = rbvalid_q;
  assign err     = err_q;
  assign ready   = (state_q == IDLE);

  always_comb begin
    sel = '0;
    for (int i = 0; i < GRID_LEN; i++) begin
      if (rqindex[i]) sel = KW'(i);
    end
    jm = lfsr_q[7:0] % (8'(k_q) + 8'd1);
    j  = KW'(jm);
  end

  always_comb begin
    tbl_d     = tbl_q;
    state_d   = state_q;
    k_d       = k_q;
    rowbias_d = rowbias_q;
    rbvalid_d = 1'b0;
    err_d     = err_q;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0);
    unique case (state_q)
      IDLE: begin
        if (updaterowbias) begin
          if (!$onehot(rqindex)) begin
            rowbias_d = '0;
            err_d     = 1'b1;
          end else if (rqindex[GRID_LEN]) begin
            state_d = SHUF;
            k_d     = KW'(GRID_LEN - 1);
          end else begin
            rowbias_d = tbl_q[sel];
            rbvalid_d = 1'b1;
          end
        end
      end
      SHUF: begin
        // Requests are rejected here; the pass runs to completion regardless.
        if (updaterowbias) err_d = 1'b1;
        tbl_d[k_q] = tbl_q[j];
        tbl_d[j]   = tbl_q[k_q];
        k_d        = k_q - KW'(1);
        if (k_q == KW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      k_q       <= '0;
      rowbias_q <= '0;
      rbvalid_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < GRID_LEN; i++) tbl_q[i] <= ONE << i;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      k_q       <= k_d;
      rowbias_q <= rowbias_d;
      rbvalid_q <= rbvalid_d;
      err_q     <= err_d;
      for (int i = 0; i < GRID_LEN; i++) tbl_q[i] <= tbl_d[i];
    end
  end

endmodule

// File: tb/tb_rowbias_server.sv
// Bench for rowbias_server: three instances (seeds ACE1, 0, 1) checked each
// cycle against a table/LFSR model, plus directed literal expectations.
module tb_rowbias_server;

  localparam int G = 9;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  logic upd   = 1'b0;
  logic [G:0] rq = '0;

  logic [G-1:0] rbA, rbZ, rbB;
  logic vA, vZ, vB, rdyA, rdyZ, rdyB, eA, eZ, eB;

  int checks = 0;
  int failures = 0;

  // model state: index 0 = seed ACE1, index 1 = seed 0001
  logic [G-1:0] mt [2][G];
  logic [15:0]  ml [2];
  int           mk [2];
  logic [G-1:0] mrb [2];
  logic         mv [2];
  logic         me [2];

  always #5 clock = ~clock;

  rowbias_server #(.GRID_LEN(G), .LFSR_SEED(16'hACE1)) dutA (
    .clock(clock), .reset(rst), .updaterowbias(upd), .rqindex(rq),
    .rowbias(rbA), .rbvalid(vA), .ready(rdyA), .err(eA));
  rowbias_server #(.GRID_LEN(G), .LFSR_SEED(16'h0000)) dutZ (
    .clock(clock), .reset(rst), .updaterowbias(upd), .rqindex(rq),
    .rowbias(rbZ), .rbvalid(vZ), .ready(rdyZ), .err(eZ));
  rowbias_server #(.GRID_LEN(G), .LFSR_SEED(16'h0001)) dutB (
    .clock(clock), .reset(rst), .updaterowbias(upd), .rqindex(rq),
    .rowbias(rbB), .rbvalid(vB), .ready(rdyB), .err(eB));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic mreset(int m, logic [15:0] seed);
    for (int i = 0; i < G; i++) mt[m][i] = G'(1) << i;
    ml[m] = seed; mk[m] = 0; mrb[m] = '0; mv[m] = 1'b0; me[m] = 1'b0;
  endtask

  task automatic mstep(int m);
    logic [15:0] lo;
    logic [G-1:0] t;
    int j, idx;
    lo = ml[m];
    ml[m] = {1'b0, lo[15:1]} ^ (lo[0] ? 16'hB400 : 16'h0);
    mv[m] = 1'b0;
    if (mk[m] > 0) begin
      if (upd) me[m] = 1'b1;
      j = int'(lo[7:0]) % (mk[m] + 1);
      t = mt[m][mk[m]]; mt[m][mk[m]] = mt[m][j]; mt[m][j] = t;
      mk[m] = mk[m] - 1;
    end else if (upd) begin
      if ($countones(rq) != 1) begin
        mrb[m] = '0; me[m] = 1'b1;
      end else if (rq[G]) begin
        mk[m] = G - 1;
      end else begin
        idx = 0;
        for (int i = 0; i < G; i++) if (rq[i]) idx = i;
        mrb[m] = mt[m][idx]; mv[m] = 1'b1;
      end
    end
  endtask

  always @(posedge clock) begin
    if (!rst) begin
      mreset(0, 16'hACE1); mreset(1, 16'h0001);
    end else begin
      mstep(0); mstep(1);
    end
    #1;
    chk("A.rowbias", 32'(rbA), 32'(mrb[0]));
    chk("A.rbvalid", 32'(vA), 32'(mv[0]));
    chk("A.ready", 32'(rdyA), 32'(mk[0] == 0));
    chk("A.err", 32'(eA), 32'(me[0]));
    chk("Z.rowbias", 32'(rbZ), 32'(mrb[0]));
    chk("Z.ready", 32'(rdyZ), 32'(mk[0] == 0));
    chk("B.rowbias", 32'(rbB), 32'(mrb[1]));
    chk("B.rbvalid", 32'(vB), 32'(mv[1]));
    chk("B.ready", 32'(rdyB), 32'(mk[1] == 0));
    chk("B.err", 32'(eB), 32'(me[1]));
  end

  int busy;

  task automatic step(logic u, logic [G:0] code);
    upd = u; rq = code;
    @(posedge clock); #3;
  endtask

  task automatic sstep(logic u, logic [G:0] code);
    step(u, code);
    if (!rdyA) busy++;
  endtask

  task automatic do_reset();
    rst = 1'b0; upd = 1'b0; rq = '0;
    @(posedge clock); @(posedge clock); #3;
    rst = 1'b1;
  endtask

  logic [G-1:0] acc;
  logic [G-1:0] seqA [G];
  logic [G-1:0] seqZ [G];
  logic [G-1:0] seqB [2][G];

  initial begin
    // 1: reset state and a simple fetch
    do_reset();
    chk("rst.ready", 32'(rdyA), 32'd1);
    chk("rst.rowbias", 32'(rbA), 32'd0);
    chk("rst.err", 32'(eA), 32'd0);
    step(1'b1, 10'b0000001000);
    chk("t1.rowbias", 32'(rbA), 32'h008);
    chk("t1.rbvalid", 32'(vA), 32'd1);
    chk("t1.ready", 32'(rdyA), 32'd1);
    step(1'b0, '0);
    chk("t1.rbvalid_drop", 32'(vA), 32'd0);

    // 2: reshuffle then fetch every entry back-to-back
    busy = 0;
    sstep(1'b1, 10'b1000000000);
    while (!rdyA && busy < 20) sstep(1'b0, '0);
    chk("t2.busy_cycles", 32'(busy), 32'd8);
    acc = '0;
    for (int i = 0; i < G; i++) begin
      step(1'b1, (G+1)'(1) << i);
      chk("t2.rbvalid", 32'(vA), 32'd1);
      chk("t2.onehot", 32'($countones(rbA)), 32'd1);
      acc |= rbA;
    end
    chk("t2.or_all", 32'(acc), 32'h1FF);

    // 3: invalid codes set sticky err; valid fetch still works
    step(1'b1, 10'b0000000011);
    chk("t3.rowbias", 32'(rbA), 32'd0);
    chk("t3.rbvalid", 32'(vA), 32'd0);
    chk("t3.err", 32'(eA), 32'd1);
    step(1'b1, '0);
    chk("t3.zero_rowbias", 32'(rbA), 32'd0);
    chk("t3.err_sticky", 32'(eA), 32'd1);
    step(1'b1, 10'b0000000100);
    chk("t3.refetch", 32'(rbA), 32'(mt[0][2]));
    chk("t3.refetch_v", 32'(vA), 32'd1);
    step(1'b0, '0);
    chk("t3.err_hold", 32'(eA), 32'd1);

    // 4: fetch during shuffle is ignored and flags err
    do_reset();
    chk("t4.err_clr", 32'(eA), 32'd0);
    busy = 0;
    sstep(1'b1, 10'b1000000000);
    sstep(1'b0, '0);
    sstep(1'b0, '0);
    sstep(1'b1, 10'b0000000001);
    chk("t4.no_valid", 32'(vA), 32'd0);
    chk("t4.err", 32'(eA), 32'd1);
    while (!rdyA && busy < 20) sstep(1'b0, '0);
    chk("t4.busy_cycles", 32'(busy), 32'd8);
    acc = '0;
    for (int i = 0; i < G; i++) begin
      step(1'b1, (G+1)'(1) << i);
      acc |= rbA;
    end
    chk("t4.or_all", 32'(acc), 32'h1FF);

    // 5: reset mid-shuffle restores identity
    do_reset();
    step(1'b1, 10'b1000000000);
    step(1'b0, '0); step(1'b0, '0); step(1'b0, '0);
    chk("t5.busy", 32'(rdyA), 32'd0);
    rst = 1'b0;
    #1;
    chk("t5.ready_async", 32'(rdyA), 32'd1);
    @(posedge clock); #3;
    rst = 1'b1;
    #1;
    chk("t5.ready_release", 32'(rdyA), 32'd1);
    for (int i = 0; i < G; i++) begin
      step(1'b1, (G+1)'(1) << i);
      chk("t5.identity", 32'(rbA), 32'(1) << i);
    end

    // 6: determinism across runs and seed-0 substitution
    for (int r = 0; r < 2; r++) begin
      do_reset();
      step(1'b0, '0); step(1'b0, '0);
      step(1'b1, 10'b1000000000);
      for (int c = 0; c < G; c++) step(1'b0, '0);
      for (int i = 0; i < G; i++) begin
        step(1'b1, (G+1)'(1) << i);
        seqB[r][i] = rbB;
        if (r == 0) begin
          seqA[i] = rbA;
          seqZ[i] = rbZ;
        end
      end
    end
    for (int i = 0; i < G; i++) begin
      chk("t6.seed1_repeat", 32'(seqB[1][i]), 32'(seqB[0][i]));
      chk("t6.seed0_eq_ace1", 32'(seqZ[i]), 32'(seqA[i]));
    end
    step(1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
